// File: rtl/seven_seg_scan.sv
// Time-multiplexed hex display driver for a common-anode 7-segment bank.
// It rotates through DIGITS slots, darkens the start of each slot and can suppress leading zeros.
module seven_seg_scan #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16,
  parameter bit          LZ_BLANK  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  enable,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] r_val;
  logic [DIGITS-1:0]   r_dp;
  logic [PW-1:0]       r_presc;
  logic [IW-1:0]       r_idx;
  logic [6:0]          r_seg;
  logic                r_dp_n;
  logic [DIGITS-1:0]   r_an;

  logic [DIGITS-1:0]   w_zero_up;
  logic [3:0]          w_nib;
  logic [DIGITS-1:0]   w_an;
  logic                w_dp_sel;
  logic                w_zero_sel;
  logic                w_sup;
  logic [6:0]          w_hex;
  logic [6:0]          w_seg_d;
  logic                w_dp_n_d;
  logic [DIGITS-1:0]   w_an_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val <= '0;
      r_dp  <= '0;
    end else if (load) begin
      r_val <= value;
      r_dp  <= dp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PW'(SCAN_DIV - 1)) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // w_zero_up[i]: digit i and every digit above it are zero.
  always_comb begin
    logic any_nz;
    any_nz    = 1'b0;
    w_zero_up = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      any_nz       = any_nz | (r_val[4*i +: 4] != 4'h0);
      w_zero_up[i] = ~any_nz;
    end
  end

  always_comb begin
    w_nib      = 4'h0;
    w_an       = '1;
    w_dp_sel   = 1'b0;
    w_zero_sel = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_idx == IW'(i)) begin
        w_nib      = r_val[4*i +: 4];
        w_an[i]    = 1'b0;
        w_dp_sel   = r_dp[i];
        w_zero_sel = w_zero_up[i];
      end
    end
  end

  assign w_sup = LZ_BLANK && (r_idx != '0) && w_zero_sel && !w_dp_sel;

  always_comb begin
    case (w_nib)
      4'h0: w_hex = 7'h40;
      4'h1: w_hex = 7'h79;
      4'h2: w_hex = 7'h24;
      4'h3: w_hex = 7'h30;
      4'h4: w_hex = 7'h19;
      4'h5: w_hex = 7'h12;
      4'h6: w_hex = 7'h02;
      4'h7: w_hex = 7'h78;
      4'h8: w_hex = 7'h00;
      4'h9: w_hex = 7'h10;
      4'hA: w_hex = 7'h08;
      4'hB: w_hex = 7'h03;
      4'hC: w_hex = 7'h46;
      4'hD: w_hex = 7'h21;
      4'hE: w_hex = 7'h06;
      default: w_hex = 7'h0E;
    endcase
  end

  // Slot stays dark while the prescaler is in the anti-ghost window.
  always_comb begin
    w_seg_d  = 7'h7F;
    w_dp_n_d = 1'b1;
    w_an_d   = '1;
    if (enable && !(r_presc < PW'(BLANK_CYC))) begin
      w_an_d   = w_an;
      w_dp_n_d = ~w_dp_sel;
      if (!w_sup) begin
        w_seg_d = w_hex;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg  <= 7'h7F;
      r_dp_n <= 1'b1;
      r_an   <= '1;
    end else begin
      r_seg  <= w_seg_d;
      r_dp_n <= w_dp_n_d;
      r_an   <= w_an_d;
    end
  end

  assign seg  = r_seg;
  assign dp_n = r_dp_n;
  assign an   = r_an;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, with and without
// leading-zero suppression, driven by identical stimulus.
module tb_seven_seg_scan;

  localparam logic [11:0] DARK = {4'hF, 7'h7F, 1'b1};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic        enable = 1'b1;
  logic [6:0]  seg_a, seg_b;
  logic        dp_n_a, dp_n_b;
  logic [3:0]  an_a, an_b;

  seven_seg_scan #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .LZ_BLANK(1'b0)) u_dut_nlz (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load), .enable(enable),
    .seg(seg_a), .dp_n(dp_n_a), .an(an_a)
  );

  seven_seg_scan #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .LZ_BLANK(1'b1)) u_dut_lz (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load), .enable(enable),
    .seg(seg_b), .dp_n(dp_n_b), .an(an_b)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          m_presc = 0;
  int          m_idx = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0;
  logic [11:0] q_nlz[$];
  logic [11:0] q_lz[$];
  logic [6:0]  seg_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Expected {an, seg, dp_n} one edge after the current model state.
  function automatic logic [11:0] model_out(input bit lz);
    logic [3:0] an_v;
    logic [6:0] s;
    int         hi;
    if (rst || !enable || m_presc < 1) return DARK;
    hi = -1;
    for (int i = 0; i < 4; i++) if (m_val[4*i +: 4] != 4'h0) hi = i;
    s = seg_tab[m_val[4*m_idx +: 4]];
    if (lz && m_idx > 0 && m_idx > hi && !m_dp[m_idx]) s = 7'h7F;
    an_v = 4'hF;
    an_v[m_idx] = 1'b0;
    return {an_v, s, ~m_dp[m_idx]};
  endfunction

  task automatic tick();
    q_nlz.push_back(model_out(1'b0));
    q_lz.push_back(model_out(1'b1));
    if (rst) begin
      m_presc = 0; m_idx = 0; m_val = '0; m_dp = '0;
    end else begin
      if (load) begin m_val = value; m_dp = dp; end
      if (m_presc == 3) begin m_presc = 0; m_idx = (m_idx + 1) % 4; end
      else m_presc++;
    end
    @(posedge clk);
    #1;
    chk("nlz", {an_a, seg_a, dp_n_a}, q_nlz.pop_front());
    chk("lz", {an_b, seg_b, dp_n_b}, q_lz.pop_front());
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    // Async reset forces outputs with no clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_async_nlz", {an_a, seg_a, dp_n_a}, DARK);
    chk("rst_async_lz", {an_b, seg_b, dp_n_b}, DARK);
    ticks(2);
    rst = 1'b0;
    ticks(2);

    do_load(16'h1234, 4'b0000);
    ticks(20);

    do_load(16'h0050, 4'b0000);
    ticks(18);
    do_load(16'h0050, 4'b1000);
    ticks(18);

    // Load during the digit-2 active slot; visible two edges later.
    for (int k = 0; k < 16 && !(m_idx == 2 && m_presc == 1); k++) tick();
    do_load(16'hFFFF, 4'b0000);
    tick();
    chk("lat_seg", {5'h0, seg_a}, {5'h0, 7'h0E});

    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("dis", {1'b0, an_a, seg_a}, {1'b0, 4'hF, 7'h7F});
    end
    enable = 1'b1;
    ticks(8);

    do_load(16'h0A0C, 4'b0101);
    ticks(12);

    // Async reset between edges mid digit 2.
    for (int k = 0; k < 16 && !(m_idx == 2 && m_presc == 2); k++) tick();
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_nlz", {an_a, seg_a, dp_n_a}, DARK);
    chk("rst_mid_lz", {an_b, seg_b, dp_n_b}, DARK);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_dark", {an_a, seg_a, dp_n_a}, DARK);
    tick();
    chk("post_rst_d0", {an_a, seg_a, dp_n_a}, {4'b1110, 7'h40, 1'b1});
    ticks(6);

    // Load coincident with a prescaler wrap.
    for (int k = 0; k < 8 && m_presc != 3; k++) tick();
    do_load(16'hABCD, 4'b0010);
    ticks(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
